// File: rtl/bk_adder_bist.sv
// bk_adder_bist
// Built-in self-test engine for the 8-bit Brent-Kung adder. It feeds LFSR-generated
// operands to an external adder and compares {Cout,Sum} against an internal golden sum.
// It counts the mismatches and keeps the first failing vector.

module bk_adder_bist #(
    parameter int unsigned NUM_VECTORS   = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic        Cin,
    input  logic [7:0]  Sum,
    input  logic        Cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [16:0] fail_vec,
    output logic [8:0]  fail_got
);

    // An all-zero seed would lock the LFSR at zero, so it falls back to the default seed
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);
    localparam int          SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [15:0]         vec_cnt;
    logic [15:0]         vec_cnt_inc;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                settle_done;
    logic                last_vec;
    logic                start_ok;
    logic [8:0]          golden;
    logic [8:0]          observed;
    logic                mismatch;
    logic                busy_d;
    logic                done_d;
    logic                pass_d;

    // A start request counts only when no run is in progress
    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign last_vec    = (vec_cnt == LAST_VEC);
    assign vec_cnt_inc = vec_cnt + 16'd1;

    // The Galois LFSR shifts right and XORs in the taps when the bit leaving it is 1
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    // The golden result comes from the registered operands, so it matches what the adder sees
    assign golden   = {1'b0, A} + {1'b0, B} + {8'b0, Cin};
    assign observed = {Cout, Sum};
    // The case-inequality makes X or Z on the adder outputs count as a mismatch in simulation
    assign mismatch = (observed !== golden);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: each vector spends SETTLE_CYCLES in DRIVE and then one cycle in CHECK
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = DRIVE;
            DRIVE:   if (settle_done) next_state = CHECK;
            CHECK:   next_state = last_vec ? DONE : DRIVE;
            DONE:    if (start_ok) next_state = DRIVE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: done and pass trail the DONE state by one cycle, and a restart clears them
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        pass_d = 1'b0;
        busy_d = (next_state == DRIVE) || (next_state == CHECK);
        done_d = (state == DONE) && !start;
        pass_d = done_d && (err_cnt == 16'h0000);
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            pass <= pass_d;
        end
    end

    // The settle counter holds the operands steady for SETTLE_CYCLES before the result is sampled
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if ((state == DRIVE) && !settle_done) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Stimulus path: the LFSR, the vector counter and the operand registers that feed the adder
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= SEED_EFF;
            vec_cnt <= 16'h0000;
            A       <= 8'h00;
            B       <= 8'h00;
            Cin     <= 1'b0;
        end else if (start_ok) begin
            lfsr    <= SEED_EFF;
            vec_cnt <= 16'h0000;
            A       <= SEED_EFF[15:8];
            B       <= SEED_EFF[7:0];
            Cin     <= 1'b0;
        end else if (state == CHECK) begin
            lfsr    <= lfsr_next;
            vec_cnt <= vec_cnt_inc;
            if (!last_vec) begin
                A   <= lfsr_next[15:8];
                B   <= lfsr_next[7:0];
                Cin <= vec_cnt_inc[0];
            end
        end
    end

    // Result checking: a saturating error count, plus a capture of the first failing vector
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt  <= 16'h0000;
            fail_vec <= 17'h00000;
            fail_got <= 9'h000;
        end else if (start_ok) begin
            err_cnt  <= 16'h0000;
            fail_vec <= 17'h00000;
            fail_got <= 9'h000;
        end else if ((state == CHECK) && mismatch) begin
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (err_cnt == 16'h0000) begin
                fail_vec <= {A, B, Cin};
                fail_got <= observed;
            end
        end
    end

endmodule
